led_rate_ctrl: RTL and testbench

- Front-end stage feeding LED_Counter. Drives its count-enable tick and its up/down direction.
- Synchronises the SW[1:0] speed select and the raw direction push-button.
- Debounces the button; each debounced press toggles direction (UD).
- Generates a one-cycle count-enable pulse (tick) whose period is selected by SW.

---
 rtl/led_rate_ctrl.sv | 149 ++++++++++++++
 tb/tb_led_rate_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/led_rate_ctrl.sv
// led_rate_ctrl: front end for LED_Counter.
// Synchronises SW and the direction button, debounces the button so that each
// accepted press toggles UD, and produces a one-cycle count-enable tick whose
// period is selected by the synchronised SW value.
module led_rate_ctrl #(
    parameter int unsigned DIV0       = 50_000_000,
    parameter int unsigned DIV1       = 25_000_000,
    parameter int unsigned DIV2       = 12_500_000,
    parameter int unsigned DIV3       = 6_250_000,
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned CW         = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] SW,
    input  logic       btn_ud,
    output logic       tick,
    output logic       UD,
    output logic [1:0] sw_q
);

    typedef enum logic [1:0] {
        STABLE_LO,
        CHK_HI,
        STABLE_HI,
        CHK_LO
    } deb_state_t;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    // Synchroniser flops
    logic [1:0]    sw_s1_q;
    logic [1:0]    sw_s2_q;
    logic          btn_s1_q;
    logic          btn_s2_q;

    // Prescaler state
    logic [1:0]    sw_prev_q, sw_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [CW-1:0] per_last;
    logic          sw_change;

    // Debounce state
    deb_state_t    deb_state_q;
    logic [CW-1:0] dcnt_q;
    logic          ud_q;

    assign sw_q = sw_s2_q;
    assign tick = tick_q;
    assign UD   = ud_q;

    // Two-flop synchronisers; nothing sits between the stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            sw_s1_q  <= SW;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= btn_ud;
            btn_s2_q <= btn_s1_q;
        end
    end

    // Period selection, SW-change detection and prescaler next state.
    always_comb begin
        unique case (sw_s2_q)
            2'd0:    per_last = CW'(DIV0 - 1);
            2'd1:    per_last = CW'(DIV1 - 1);
            2'd2:    per_last = CW'(DIV2 - 1);
            default: per_last = CW'(DIV3 - 1);
        endcase
        sw_change = (sw_s2_q != sw_prev_q);
        sw_prev_d = sw_s2_q;
        cnt_d     = cnt_q + CW'(1);
        tick_d    = 1'b0;
        if (sw_change) begin
            // Restart the period so the new rate never yields a short or long gap.
            cnt_d = '0;
        end else if (cnt_q == per_last) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Prescaler registers with registered tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_prev_q <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            sw_prev_q <= sw_prev_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
        end
    end

    // Debounce FSM; UD toggles only when a high level is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_state_q <= STABLE_LO;
            dcnt_q      <= '0;
            ud_q        <= 1'b1;
        end else begin
            unique case (deb_state_q)
                STABLE_LO: begin
                    if (btn_s2_q) begin
                        deb_state_q <= CHK_HI;
                        dcnt_q      <= '0;
                    end
                end
                CHK_HI: begin
                    if (!btn_s2_q) begin
                        deb_state_q <= STABLE_LO;
                    end else if (dcnt_q == DEB_LAST) begin
                        deb_state_q <= STABLE_HI;
                        ud_q        <= ~ud_q;
                    end else begin
                        dcnt_q <= dcnt_q + CW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!btn_s2_q) begin
                        deb_state_q <= CHK_LO;
                        dcnt_q      <= '0;
                    end
                end
                CHK_LO: begin
                    if (btn_s2_q) begin
                        deb_state_q <= STABLE_HI;
                    end else if (dcnt_q == DEB_LAST) begin
                        deb_state_q <= STABLE_LO;
                    end else begin
                        dcnt_q <= dcnt_q + CW'(1);
                    end
                end
                default: begin
                    deb_state_q <= STABLE_LO;
                    dcnt_q      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_rate_ctrl.sv
// Directed bench for led_rate_ctrl with small dividers (4/8/16/32) and a
// 5-sample debounce. Inputs change 1 ns after a rising edge; outputs are
// sampled 1 ns after a rising edge.
module tb_led_rate_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] SW;
    logic       btn_ud;
    logic       tick;
    logic       UD;
    logic [1:0] sw_q;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    led_rate_ctrl #(
        .DIV0(4),
        .DIV1(8),
        .DIV2(16),
        .DIV3(32),
        .DEB_CYCLES(5),
        .CW(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .SW(SW),
        .btn_ud(btn_ud),
        .tick(tick),
        .UD(UD),
        .sw_q(sw_q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count rising edges until tick is seen; 999 means no tick within 100 edges.
    task automatic wait_tick(output int cycles);
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (tick) break;
        end
        if (!tick) cycles = 999;
    endtask

    // Button press held long enough for acceptance, then a long release.
    task automatic press_release();
        btn_ud = 1'b1;
        step(10);
        btn_ud = 1'b0;
        step(20);
    endtask

    initial begin
        reset  = 1'b1;
        SW     = 2'd0;
        btn_ud = 1'b0;
        #1;
        check_eq("reset_ud", UD, 1);
        check_eq("reset_tick", tick, 0);
        check_eq("reset_swq", sw_q, 0);
        @(posedge clk);
        #1;
        check_eq("reset_tick_edge", tick, 0);
        #9;
        reset = 1'b0;

        // SW=0: first tick 4 edges after deassert, then every 4.
        wait_tick(n);
        check_eq("first_tick", n, 4);
        for (int i = 0; i < 9; i++) begin
            wait_tick(n);
            check_eq("period_div0", n, 4);
        end

        // SW 0->2 one cycle after a tick: sw_q follows after 2 edges,
        // the change edge clears the prescaler, next tick 16 edges later.
        step(1);
        SW = 2'd2;
        step(1);
        check_eq("swq_lat1", sw_q, 0);
        step(1);
        check_eq("swq_lat2", sw_q, 2);
        step(1);
        check_eq("change_cycle_tick", tick, 0);
        wait_tick(n);
        check_eq("tick_after_change", n, 16);
        wait_tick(n);
        check_eq("period_div2_a", n, 16);
        wait_tick(n);
        check_eq("period_div2_b", n, 16);

        // Clean press held 20 cycles. Edge counted from the clock edge that
        // first samples the pin: UD flips 7 edges after it.
        btn_ud = 1'b1;
        step(7);
        check_eq("ud_pre_toggle", UD, 1);
        step(1);
        check_eq("ud_toggle", UD, 0);
        step(12);
        check_eq("ud_hold", UD, 0);
        btn_ud = 1'b0;
        step(20);
        check_eq("ud_release", UD, 0);

        // Bounce: 3 high / 2 low x5 never reaches acceptance.
        for (int i = 0; i < 5; i++) begin
            btn_ud = 1'b1;
            step(3);
            btn_ud = 1'b0;
            step(2);
        end
        check_eq("ud_bounce", UD, 0);
        btn_ud = 1'b1;
        step(7);
        check_eq("ud_bounce_pre", UD, 0);
        step(1);
        check_eq("ud_bounce_toggle", UD, 1);
        step(12);
        btn_ud = 1'b0;
        step(20);
        check_eq("ud_bounce_release", UD, 1);

        // Two clean presses: 1 -> 0 -> 1.
        btn_ud = 1'b1;
        step(10);
        check_eq("press1", UD, 0);
        btn_ud = 1'b0;
        step(20);
        btn_ud = 1'b1;
        step(10);
        check_eq("press2", UD, 1);
        btn_ud = 1'b0;
        step(20);

        // Reset during CHK_HI with dcnt=3, UD=0, SW=3.
        SW = 2'd3;
        press_release();
        check_eq("ud_before_reset", UD, 0);
        check_eq("swq_before_reset", sw_q, 3);
        btn_ud = 1'b1;
        step(6);
        check_eq("ud_chk_hi", UD, 0);
        reset  = 1'b1;
        btn_ud = 1'b0;
        #1;
        check_eq("midrst_ud", UD, 1);
        check_eq("midrst_tick", tick, 0);
        check_eq("midrst_swq", sw_q, 0);
        step(3);
        check_eq("midrst_tick_hold", tick, 0);
        check_eq("midrst_swq_hold", sw_q, 0);
        reset = 1'b0;
        // sw_q reaches 3 on edge 2, change seen on edge 3, tick 32 edges later.
        wait_tick(n);
        check_eq("post_rst_first_tick", n, 35);
        wait_tick(n);
        check_eq("post_rst_period", n, 32);
        check_eq("post_rst_ud", UD, 1);
        check_eq("post_rst_swq", sw_q, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
